// File: rtl/feed_msg_tx.sv
// Market-data record transmitter. A small FIFO buffers parsed tick records, and each record
// is sent as a two-beat Avalon-ST packet: a header stamped with a sequence number, then a body.
module feed_msg_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_type,
  input  logic [15:0]                   in_symbol,
  input  logic [31:0]                   in_price,
  input  logic [31:0]                   in_volume,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [63:0]                   dec_data,
  output logic                          dec_sop,
  output logic                          dec_eop,
  output logic [15:0]                   seq_num,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]  typ;
    logic [15:0] symbol;
    logic [31:0] price;
    logic [31:0] volume;
  } rec_t;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  rec_t        mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  rec_t        head_rec;
  rec_t        in_rec;
  logic [63:0] body_hold;
  state_t      state;

  function automatic logic [63:0] hdr_beat(input rec_t r, input logic [15:0] seq);
    hdr_beat = {24'h00_0000, r.symbol, seq, r.typ};
  endfunction

  function automatic logic [63:0] body_beat(input rec_t r);
    body_beat = {r.price, r.volume};
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && ((state == IDLE) || ((state == BODY) && dec_ready));
  assign head_rec = mem[rd_ptr[AW-1:0]];
  assign in_rec   = '{typ: in_type, symbol: in_symbol, price: in_price, volume: in_volume};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      body_hold <= body_beat(head_rec);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // The sequence number advances on header acceptance, so the next header loaded
  // from BODY already carries the incremented value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dec_valid <= 1'b0;
      dec_data  <= '0;
      dec_sop   <= 1'b0;
      dec_eop   <= 1'b0;
      seq_num   <= SEQ_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            dec_data  <= hdr_beat(head_rec, seq_num);
            dec_sop   <= 1'b1;
            dec_eop   <= 1'b0;
            dec_valid <= 1'b1;
            state     <= HDR;
          end
        end
        HDR: begin
          if (dec_ready) begin
            seq_num  <= seq_num + 16'd1;
            dec_data <= body_hold;
            dec_sop  <= 1'b0;
            dec_eop  <= 1'b1;
            state    <= BODY;
          end
        end
        BODY: begin
          if (dec_ready) begin
            if (!empty) begin
              dec_data <= hdr_beat(head_rec, seq_num);
              dec_sop  <= 1'b1;
              dec_eop  <= 1'b0;
              state    <= HDR;
            end else begin
              dec_valid <= 1'b0;
              dec_sop   <= 1'b0;
              dec_eop   <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          dec_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
